// File: rtl/gpu_pkg.sv
// Shared constants for the GPU command port: GP1 opcodes, status bit positions and
// display register reset defaults.
package gpu_pkg;

  typedef enum logic [7:0] {
    GP1_RESET      = 8'h00,
    GP1_FLUSH      = 8'h01,
    GP1_DISP_EN    = 8'h03,
    GP1_DISP_START = 8'h05,
    GP1_DISP_MODE  = 8'h08
  } gp1_op_e;

  localparam int unsigned STAT_OVERFLOW = 31;
  localparam int unsigned STAT_NOT_FULL = 28;
  localparam int unsigned STAT_EMPTY    = 26;
  localparam int unsigned STAT_DISP_OFF = 23;
  localparam int unsigned STAT_COLOR    = 21;
  localparam int unsigned STAT_HEIGHT   = 19;
  localparam int unsigned STAT_HRES_LO  = 17;
  localparam int unsigned STAT_W368     = 16;

  localparam logic [9:0] DISP_W_RESET = 10'd320;
  localparam logic [9:0] DISP_H_RESET = 10'd240;
  // Raw hres value consistent with the 320-pixel reset width
  localparam logic [1:0] HRES_RESET   = 2'b01;

  function automatic logic [9:0] mode_width(input logic [1:0] hres, input logic w368);
    logic [9:0] w;
    unique case (hres)
      2'b00:   w = 10'd256;
      2'b01:   w = 10'd320;
      2'b10:   w = 10'd512;
      default: w = 10'd640;
    endcase
    if (w368) w = 10'd368;
    return w;
  endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// First-word-fall-through GP0 command FIFO with flush, occupancy count, early-full
// threshold and sticky overflow flag.
module gpu_cmd_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned FULL_MARGIN = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  input  logic                     rd_ready,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, ovf_q, ovf_d, valid_q, valid_d;
  logic          pop, push, mem_we;

  always_comb begin
    pop      = valid_q & rd_ready;
    // A pop in the same cycle frees the slot, so a push at DEPTH is still legal
    push     = wr_en & ((count_q < CW'(DEPTH)) | pop);
    mem_we   = push & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (wr_en && !push) ovf_d = 1'b1;
    end
    full_d  = (count_d >= CW'(DEPTH - FULL_MARGIN));
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is deliberately not reset; only pointers and count are
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem[rd_ptr_q];
  assign rd_valid = valid_q;
  assign count    = count_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/gpu_cmd_port.sv
// GPU-side command receiver: buffers GP0 words for the rasterizer, decodes GP1 words
// into display-control registers and assembles the GPU status word.
module gpu_cmd_port
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned FULL_MARGIN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] main_bus,
  input  logic        to_gp0,
  input  logic        to_gp1,
  output logic        fifo_full,
  output logic [31:0] cmd_word,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  display_x,
  output logic [9:0]  display_y,
  output logic [9:0]  display_w,
  output logic [9:0]  display_h,
  output logic        display_color_mode,
  output logic        display_enable,
  output logic [31:0] gpu_stat
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [7:0]    op;
  logic          flush, overflow;
  logic [CW-1:0] fifo_count;

  logic [9:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [1:0] hres_q, hres_d;
  logic       h480_q, h480_d, w368_q, w368_d, color_q, color_d, en_q, en_d;

  assign op    = main_bus[31:24];
  assign flush = to_gp1 & ((op == GP1_RESET) | (op == GP1_FLUSH));

  gpu_cmd_fifo #(
    .DEPTH       (DEPTH),
    .FULL_MARGIN (FULL_MARGIN)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .wr_en    (to_gp0),
    .wr_data  (main_bus),
    .rd_ready (cmd_ready),
    .rd_data  (cmd_word),
    .rd_valid (cmd_valid),
    .count    (fifo_count),
    .full     (fifo_full),
    .overflow (overflow)
  );

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    hres_d  = hres_q;
    h480_d  = h480_q;
    w368_d  = w368_q;
    color_d = color_q;
    en_d    = en_q;
    if (to_gp1) begin
      case (op)
        GP1_RESET: begin
          x_d     = '0;
          y_d     = '0;
          w_d     = DISP_W_RESET;
          h_d     = DISP_H_RESET;
          hres_d  = HRES_RESET;
          h480_d  = 1'b0;
          w368_d  = 1'b0;
          color_d = 1'b0;
          en_d    = 1'b0;
        end
        GP1_DISP_EN: en_d = ~main_bus[0];
        GP1_DISP_START: begin
          x_d = main_bus[9:0];
          y_d = {1'b0, main_bus[18:10]};
        end
        GP1_DISP_MODE: begin
          hres_d  = main_bus[1:0];
          w368_d  = main_bus[6];
          h480_d  = main_bus[2];
          color_d = main_bus[4];
          w_d     = mode_width(main_bus[1:0], main_bus[6]);
          h_d     = main_bus[2] ? 10'd480 : 10'd240;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= DISP_W_RESET;
      h_q     <= DISP_H_RESET;
      hres_q  <= HRES_RESET;
      h480_q  <= 1'b0;
      w368_q  <= 1'b0;
      color_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      hres_q  <= hres_d;
      h480_q  <= h480_d;
      w368_q  <= w368_d;
      color_q <= color_d;
      en_q    <= en_d;
    end
  end

  assign display_x          = x_q;
  assign display_y          = y_q;
  assign display_w          = w_q;
  assign display_h          = h_q;
  assign display_color_mode = color_q;
  assign display_enable     = en_q;

  always_comb begin
    gpu_stat                  = '0;
    gpu_stat[STAT_OVERFLOW]   = overflow;
    gpu_stat[STAT_NOT_FULL]   = ~fifo_full;
    gpu_stat[STAT_EMPTY]      = ~cmd_valid;
    gpu_stat[STAT_DISP_OFF]   = ~en_q;
    gpu_stat[STAT_COLOR]      = color_q;
    gpu_stat[STAT_HEIGHT]     = h480_q;
    gpu_stat[STAT_HRES_LO+:2] = hres_q;
    gpu_stat[STAT_W368]       = w368_q;
    gpu_stat[7:0]             = 8'(fifo_count);
  end

endmodule

// File: tb/tb_gpu_cmd_port.sv
// Self-checking bench for gpu_cmd_port: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_gpu_cmd_port;

  localparam int DEPTH = 16;
  localparam int MARGIN = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] main_bus;
  logic        to_gp0, to_gp1, cmd_ready;
  logic        fifo_full, cmd_valid, display_color_mode, display_enable;
  logic [31:0] cmd_word, gpu_stat;
  logic [9:0]  display_x, display_y, display_w, display_h;

  always #5 clk = ~clk;

  gpu_cmd_port #(
    .DEPTH       (DEPTH),
    .FULL_MARGIN (MARGIN)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .main_bus           (main_bus),
    .to_gp0             (to_gp0),
    .to_gp1             (to_gp1),
    .fifo_full          (fifo_full),
    .cmd_word           (cmd_word),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .display_x          (display_x),
    .display_y          (display_y),
    .display_w          (display_w),
    .display_h          (display_h),
    .display_color_mode (display_color_mode),
    .display_enable     (display_enable),
    .gpu_stat           (gpu_stat)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          movf;
  int          m_x, m_y, m_hres;
  bit          m_h480, m_368, m_col, m_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int model_width();
    if (m_368) return 368;
    case (m_hres)
      0: return 256;
      1: return 320;
      2: return 512;
      default: return 640;
    endcase
  endfunction

  task automatic model_disp_reset();
    m_x = 0; m_y = 0; m_hres = 1; m_h480 = 0; m_368 = 0; m_col = 0; m_en = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    movf = 0;
    model_disp_reset();
  endtask

  // One clock edge of the command port, from the input pins at the edge
  task automatic model_clock();
    int   sz  = mq.size();
    int   op  = int'(main_bus[31:24]);
    bit   pop = (sz > 0) && cmd_ready;
    if (to_gp1 && (op == 0 || op == 1)) begin
      mq.delete();
      movf = 0;
      if (op == 0) model_disp_reset();
    end else begin
      if (pop) void'(mq.pop_front());
      if (to_gp0) begin
        if (sz < DEPTH || pop) mq.push_back(main_bus);
        else movf = 1;
      end
      if (to_gp1) begin
        case (op)
          3: m_en = ~main_bus[0];
          5: begin
            m_x = int'(main_bus[9:0]);
            m_y = int'(main_bus[18:10]);
          end
          8: begin
            m_hres = int'(main_bus[1:0]);
            m_h480 = main_bus[2];
            m_col  = main_bus[4];
            m_368  = main_bus[6];
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    int          sz   = mq.size();
    bit          full = (sz >= DEPTH - MARGIN);
    logic [31:0] exp  = '0;
    check("fifo_full", 32'(fifo_full), 32'(full));
    check("cmd_valid", 32'(cmd_valid), 32'(sz > 0));
    if (sz > 0) check("cmd_word", cmd_word, mq[0]);
    check("display_x", 32'(display_x), 32'(m_x));
    check("display_y", 32'(display_y), 32'(m_y));
    check("display_w", 32'(display_w), 32'(model_width()));
    check("display_h", 32'(display_h), m_h480 ? 32'd480 : 32'd240);
    check("color_mode", 32'(display_color_mode), 32'(m_col));
    check("display_enable", 32'(display_enable), 32'(m_en));
    exp[31]    = movf;
    exp[28]    = !full;
    exp[26]    = (sz == 0);
    exp[23]    = !m_en;
    exp[21]    = m_col;
    exp[19]    = m_h480;
    exp[18:17] = 2'(m_hres);
    exp[16]    = m_368;
    exp[7:0]   = 8'(sz);
    check("gpu_stat", gpu_stat, exp);
  endtask

  task automatic step(input bit g0, input bit g1, input logic [31:0] bus, input bit rdy);
    to_gp0    = g0;
    to_gp1    = g1;
    main_bus  = bus;
    cmd_ready = rdy;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; to_gp0 = 0; to_gp1 = 0; main_bus = '0; cmd_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_w", 32'(display_w), 32'd320);
    check("reset_stat", gpu_stat, 32'h1482_0000);
    rst_n = 1'b1;

    // Display mode, start and enable
    step(0, 1, 32'h0800_0017, 0);
    check("mode_w", 32'(display_w), 32'd640);
    check("mode_h", 32'(display_h), 32'd480);
    check("mode_stat", gpu_stat & 32'h002E_0000, 32'h002E_0000);
    step(0, 1, 32'h0500_2C0A, 0);
    check("start_x", 32'(display_x), 32'd10);
    check("start_y", 32'(display_y), 32'd11);
    step(0, 1, 32'h0300_0000, 0);
    check("enable", 32'(display_enable), 32'd1);
    check("stat_disp_off", 32'(gpu_stat[23]), 32'd0);

    // Fill to DEPTH, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 32'hA000_0000 + 32'(i), 0);
      if (i == 13) check("full_at_14", 32'(fifo_full), 32'd0);
      if (i == 14) check("full_at_15", 32'(fifo_full), 32'd1);
    end
    check("count_16", 32'(gpu_stat[7:0]), 32'd16);
    step(1, 0, 32'hA000_0010, 0);
    check("overflow", 32'(gpu_stat[31]), 32'd1);
    check("count_after_ovf", 32'(gpu_stat[7:0]), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("drain_word", cmd_word, 32'hA000_0000 + 32'(i));
      step(0, 0, 32'h0, 1);
    end
    check("drained_valid", 32'(cmd_valid), 32'd0);

    // Push and pop together at DEPTH
    step(0, 1, 32'h0100_0000, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 32'hD000_0000 + 32'(i), 0);
    step(1, 0, 32'hB000_0001, 1);
    check("pushpop_count", 32'(gpu_stat[7:0]), 32'd16);
    check("pushpop_ovf", 32'(gpu_stat[31]), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("pushpop_last", cmd_word, 32'hB000_0001);
      step(0, 0, 32'h0, 1);
    end

    // Flush concurrent with GP0 write and pop
    for (int i = 0; i < 4; i++) step(1, 0, 32'hC000_0000 + 32'(i), 0);
    step(1, 1, 32'h0100_0000, 1);
    check("flush_count", 32'(gpu_stat[7:0]), 32'd0);
    check("flush_valid", 32'(cmd_valid), 32'd0);
    check("flush_w_kept", 32'(display_w), 32'd640);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) step(1, 0, 32'hE000_0000 + 32'(i), 0);
    to_gp0 = 0; cmd_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_w", 32'(display_w), 32'd320);
    check("async_h", 32'(display_h), 32'd240);
    check("async_stat", gpu_stat & 32'h1400_0000, 32'h1400_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int          rdy_pct = ((c / 200) % 2 == 0) ? 20 : 85;
      bit          g0      = ($urandom_range(99, 0) < 60);
      bit          g1      = ($urandom_range(99, 0) < 4);
      bit          rdy     = ($urandom_range(99, 0) < rdy_pct);
      logic [7:0]  op;
      logic [31:0] bus;
      case ($urandom_range(6, 0))
        0: op = 8'h00;
        1: op = 8'h01;
        2: op = 8'h03;
        3: op = 8'h05;
        4, 5: op = 8'h08;
        default: op = 8'($urandom);
      endcase
      bus = g1 ? {op, 24'($urandom)} : $urandom;
      step(g0, g1, bus, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
